neuron_seq_mac: RTL

//  Time-multiplexed FP16 neuron. One shared hp_mul and one shared float_adder compute result = act(sum_k x[k]*w[k] + bias).

---
 rtl/neuron_seq_mac.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/neuron_seq_mac.sv
// Time-multiplexed FP16 neuron: result = act(sum_k x[k]*w[k] + bias) through one multiplier and one adder.
// Define RELU6_EN to clamp the result to [0, 6]; otherwise the raw biased sum is emitted.
module neuron_seq_mac #(
    parameter  int N     = 4,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

    state_t           state_q;
    logic [15:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      bias_q;
    logic             out_valid_q;
    logic [15:0]      result_q;
    logic [15:0]      prod;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      sum_d;
    logic             beat;

    // Round-to-nearest-even and pack; subnormal results flush to signed zero.
    function automatic logic [15:0] fp_pack(input logic s, input logic signed [7:0] e,
                                            input logic [10:0] m, input logic g, input logic st);
        logic [11:0]       r;
        logic signed [7:0] ee;
        r  = {1'b0, m} + {11'd0, g & (st | m[0])};
        ee = e;
        if (r[11]) begin
            r  = r >> 1;
            ee = ee + 8'sd1;
        end
        if (ee >= 8'sd31)     fp_pack = {s, 5'h1f, 10'h000};
        else if (ee <= 8'sd0) fp_pack = {s, 15'h0000};
        else                  fp_pack = {s, ee[4:0], r[9:0]};
    endfunction

    function automatic logic is_nan(input logic [15:0] v);
        is_nan = (v[14:10] == 5'h1f) && (v[9:0] != 10'h000);
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic              s;
        logic [21:0]       p;
        logic signed [7:0] e;
        s = a[15] ^ b[15];
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (is_nan(a) || is_nan(b))
            fp_mul = QNAN;
        else if (a[14:10] == 5'h1f || b[14:10] == 5'h1f)
            fp_mul = (a[14:10] == 5'h00 || b[14:10] == 5'h00) ? QNAN : {s, 5'h1f, 10'h000};
        else if (a[14:10] == 5'h00 || b[14:10] == 5'h00)
            fp_mul = {s, 15'h0000};
        else if (p[21])
            fp_mul = fp_pack(s, e + 8'sd1, p[21:11], p[10], |p[9:0]);
        else
            fp_mul = fp_pack(s, e, p[20:10], p[9], |p[8:0]);
    endfunction

    // The smaller operand is aligned with guard, round and sticky bits below its LSB.
    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0]       big;
        logic [15:0]       sml;
        logic [4:0]        d;
        logic [13:0]       am;
        logic [13:0]       bm;
        logic [29:0]       sh;
        logic [14:0]       sum;
        logic [14:0]       nrm;
        logic signed [7:0] e;
        int                lz;
        if (is_nan(a) || is_nan(b))
            fp_add = QNAN;
        else if (a[14:10] == 5'h1f && b[14:10] == 5'h1f)
            fp_add = (a[15] != b[15]) ? QNAN : a;
        else if (a[14:10] == 5'h1f)
            fp_add = a;
        else if (b[14:10] == 5'h1f)
            fp_add = b;
        else if (a[14:10] == 5'h00 && b[14:10] == 5'h00)
            fp_add = {a[15] & b[15], 15'h0000};
        else if (a[14:10] == 5'h00)
            fp_add = b;
        else if (b[14:10] == 5'h00)
            fp_add = a;
        else begin
            big = (a[14:0] >= b[14:0]) ? a : b;
            sml = (a[14:0] >= b[14:0]) ? b : a;
            d   = big[14:10] - sml[14:10];
            am  = {1'b1, big[9:0], 3'b000};
            sh  = {1'b1, sml[9:0], 3'b000, 16'h0000} >> d;
            bm  = {sh[29:17], sh[16] | (|sh[15:0])};
            sum = (big[15] == sml[15]) ? ({1'b0, am} + {1'b0, bm}) : ({1'b0, am} - {1'b0, bm});
            e   = $signed({3'b000, big[14:10]});
            lz  = 0;
            for (int i = 0; i < 14; i++)
                if (sum[i]) lz = 13 - i;
            nrm = sum << lz;
            if (sum == 15'h0000)
                fp_add = 16'h0000;
            else if (sum[14])
                fp_add = fp_pack(big[15], e + 8'sd1, sum[14:4], sum[3], |sum[2:0]);
            else
                fp_add = fp_pack(big[15], e - $signed(8'(lz)), nrm[13:3], nrm[2], |nrm[1:0]);
        end
    endfunction

`ifdef RELU6_EN
    function automatic logic [15:0] relu6(input logic [15:0] v);
        if (v[15])                    relu6 = 16'h0000;
        else if (v[14:0] > 15'h4600)  relu6 = 16'h4600;
        else                          relu6 = v;
    endfunction
`endif

    assign beat     = in_valid & in_ready;
    assign in_ready = ((state_q == IDLE) || (state_q == ACCUM)) && !clear;
    assign busy     = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // The single adder takes 0 + x*w on the first beat, acc + x*w after, acc + bias in BIAS.
    always_comb begin
        prod  = fp_mul(in_x, in_w);
        add_a = (state_q == IDLE) ? 16'h0000 : acc_q;
        add_b = (state_q == BIAS) ? bias_q : prod;
        sum_d = fp_add(add_a, add_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 16'h0000;
            cnt_q       <= '0;
            bias_q      <= 16'h0000;
            out_valid_q <= 1'b0;
            result_q    <= 16'h0000;
        end else if (clear) begin
            state_q     <= IDLE;
            acc_q       <= 16'h0000;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (beat) begin
                    acc_q   <= sum_d;
                    bias_q  <= bias;
                    cnt_q   <= CNT_W'(1);
                    state_q <= (N == 1) ? BIAS : ACCUM;
                end
                ACCUM: if (beat) begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) state_q <= BIAS;
                end
                BIAS: begin
                    acc_q       <= sum_d;
`ifdef RELU6_EN
                    result_q    <= relu6(sum_d);
`else
                    result_q    <= sum_d;
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    acc_q       <= 16'h0000;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
